// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares one register-file write port between the WB-stage
// pipe and a long-latency MDU. MDU results pass through a one-entry holding
// buffer. The pipe normally wins arbitration; once the buffer has lost
// MAX_WAIT times, the buffer is forced through and the pipe is stalled.
// Also keeps a scoreboard of registers that are waiting on an MDU result.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   flush                            pipeline-wide flush
//   pipe_valid/we/reg/data           WB-stage writeback request
//   pipe_ready                       WB request accepted (combinational)
//   mdu_valid/reg/data               MDU result
//   mdu_ready                        MDU result accepted (combinational)
//   mdu_issue_valid/reg              MDU op issued, destination register
//   rf_en/rf_waddr/rf_wdata          registered RF write port
//   busy                             scoreboard, bit n = x[n] awaits MDU
module rf_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        pipe_valid,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    output logic        pipe_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        mdu_issue_valid,
    input  logic [4:0]  mdu_issue_reg,
    output logic        rf_en,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy
);

    localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;

    logic [1:0]     r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic [4:0]     r_buf_reg;
    logic [31:0]    r_buf_data;
    logic [31:0]    r_busy;

    logic [1:0]     w_nstate;
    logic [WCW-1:0] w_ncnt;
    logic [WCW-1:0] w_cnt_inc;
    logic           w_pipe_need;
    logic           w_pipe_grant;
    logic           w_buf_grant;
    logic           w_buf_full;
    logic           w_buf_wr;
    logic           w_load;
    logic [31:0]    w_busy_set;
    logic [31:0]    w_busy_clr;

    assign w_pipe_need = pipe_valid && pipe_we && (pipe_reg != 5'd0);
    assign busy        = r_busy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_nstate;
            r_wait_cnt <= w_ncnt;
        end
    end

    // Arbitration, handshakes and next state
    always_comb begin
        w_nstate     = r_state;
        w_ncnt       = r_wait_cnt;
        w_cnt_inc    = r_wait_cnt + WCW'(1);
        w_pipe_grant = 1'b0;
        w_buf_grant  = 1'b0;
        pipe_ready   = 1'b1;
        // An unknown state code is treated as an empty buffer and recovers to IDLE
        w_buf_full   = (r_state == S_PEND) || (r_state == S_FORCE);

        case (r_state)
            S_IDLE: begin
                w_pipe_grant = w_pipe_need;
            end
            S_PEND: begin
                w_pipe_grant = w_pipe_need;
                w_buf_grant  = !w_pipe_need;
            end
            S_FORCE: begin
                w_buf_grant = 1'b1;
                pipe_ready  = !w_pipe_need;
            end
            default: begin
                w_pipe_grant = 1'b0;
            end
        endcase

        mdu_ready = !w_buf_full || w_buf_grant;
        // x0 results and anything arriving under flush are accepted but not kept
        w_load    = mdu_valid && mdu_ready && (mdu_reg != 5'd0) && !flush;
        // A flushed buffer is discarded rather than written
        w_buf_wr  = w_buf_grant && !flush;

        if (flush) begin
            w_nstate = S_IDLE;
            w_ncnt   = '0;
        end else if (!w_buf_full || w_buf_grant) begin
            if (w_load) begin
                w_nstate = (MAX_WAIT == 0) ? S_FORCE : S_PEND;
            end else begin
                w_nstate = S_IDLE;
            end
            w_ncnt = '0;
        end else begin
            // Only PEND can lose arbitration, so the count never passes MAX_WAIT
            w_ncnt   = w_cnt_inc;
            w_nstate = (w_cnt_inc == WCW'(MAX_WAIT)) ? S_FORCE : S_PEND;
        end
    end

    // Holding buffer payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_reg  <= 5'd0;
            r_buf_data <= 32'd0;
        end else if (w_load) begin
            r_buf_reg  <= mdu_reg;
            r_buf_data <= mdu_data;
        end
    end

    // Scoreboard: set has priority over clear, bit 0 tied low
    always_comb begin
        w_busy_set = 32'd0;
        w_busy_clr = 32'd0;
        if (mdu_issue_valid && (mdu_issue_reg != 5'd0) && !flush) begin
            w_busy_set = 32'd1 << mdu_issue_reg;
        end
        if (w_buf_wr) begin
            w_busy_clr = 32'd1 << r_buf_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 32'd0;
        end else if (flush) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
        end
    end

    // Registered RF write port; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_en <= w_pipe_grant || w_buf_wr;
            if (w_pipe_grant) begin
                rf_waddr <= pipe_reg;
                rf_wdata <= pipe_data;
            end else if (w_buf_wr) begin
                rf_waddr <= r_buf_reg;
                rf_wdata <= r_buf_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (MAX_WAIT = 4).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        pipe_valid;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        pipe_ready;
    logic        mdu_valid;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        mdu_issue_valid;
    logic [4:0]  mdu_issue_reg;
    logic        rf_en;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int n_total = 0;
    int n_bad   = 0;

    rf_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .pipe_valid      (pipe_valid),
        .pipe_we         (pipe_we),
        .pipe_reg        (pipe_reg),
        .pipe_data       (pipe_data),
        .pipe_ready      (pipe_ready),
        .mdu_valid       (mdu_valid),
        .mdu_reg         (mdu_reg),
        .mdu_data        (mdu_data),
        .mdu_ready       (mdu_ready),
        .mdu_issue_valid (mdu_issue_valid),
        .mdu_issue_reg   (mdu_issue_reg),
        .rf_en           (rf_en),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush           = 1'b0;
        pipe_valid      = 1'b0;
        pipe_we         = 1'b0;
        pipe_reg        = 5'd0;
        pipe_data       = 32'd0;
        mdu_valid       = 1'b0;
        mdu_reg         = 5'd0;
        mdu_data        = 32'd0;
        mdu_issue_valid = 1'b0;
        mdu_issue_reg   = 5'd0;
    endtask

    task automatic drive_pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
        pipe_valid = 1'b1;
        pipe_we    = we;
        pipe_reg   = r;
        pipe_data  = d;
    endtask

    task automatic drive_mdu(input logic [4:0] r, input logic [31:0] d);
        mdu_valid = 1'b1;
        mdu_reg   = r;
        mdu_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("reset_rf_en", 32'(rf_en), 32'd0);
        chk("reset_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_wdata", rf_wdata, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_pipe_ready", 32'(pipe_ready), 32'd1);
        chk("reset_mdu_ready", 32'(mdu_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain pipe write, first edge after reset release
        drive_pipe(1'b1, 5'd5, 32'h1234_5678);
        #1;
        chk("p5_ready", 32'(pipe_ready), 32'd1);
        tick();
        chk("p5_en", 32'(rf_en), 32'd1);
        chk("p5_addr", 32'(rf_waddr), 32'd5);
        chk("p5_data", rf_wdata, 32'h1234_5678);
        idle_inputs();
        tick();
        chk("p5_en_off", 32'(rf_en), 32'd0);
        chk("p5_addr_hold", 32'(rf_waddr), 32'd5);
        chk("p5_data_hold", rf_wdata, 32'h1234_5678);

        // Issue x7, MDU result later, written 2 edges after mdu_valid
        mdu_issue_valid = 1'b1;
        mdu_issue_reg   = 5'd7;
        tick();
        idle_inputs();
        chk("busy7_set", busy, 32'h0000_0080);
        tick();
        drive_mdu(5'd7, 32'hDEAD_BEEF);
        #1;
        chk("m7_mdu_ready", 32'(mdu_ready), 32'd1);
        tick();
        idle_inputs();
        chk("m7_en_early", 32'(rf_en), 32'd0);
        chk("m7_busy_held", busy, 32'h0000_0080);
        tick();
        chk("m7_en", 32'(rf_en), 32'd1);
        chk("m7_addr", 32'(rf_waddr), 32'd7);
        chk("m7_data", rf_wdata, 32'hDEAD_BEEF);
        chk("m7_busy_clr", busy, 32'd0);

        // x9 buffered, pipe busy every cycle: 4 pipe wins, then forced
        drive_mdu(5'd9, 32'h0000_0099);
        tick();
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            drive_pipe(1'b1, 5'(k), 32'(k));
            #1;
            chk("starve_pipe_ready", 32'(pipe_ready), 32'd1);
            tick();
            chk("starve_pipe_addr", 32'(rf_waddr), 32'(k));
        end
        drive_pipe(1'b1, 5'd11, 32'h0000_0011);
        #1;
        chk("force_pipe_ready", 32'(pipe_ready), 32'd0);
        chk("force_mdu_ready", 32'(mdu_ready), 32'd1);
        tick();
        chk("force_en", 32'(rf_en), 32'd1);
        chk("force_addr", 32'(rf_waddr), 32'd9);
        chk("force_data", rf_wdata, 32'h0000_0099);
        chk("resume_pipe_ready", 32'(pipe_ready), 32'd1);
        tick();
        chk("resume_addr", 32'(rf_waddr), 32'd11);
        idle_inputs();

        // Buffer drained and refilled in the same cycle; count restarts
        drive_mdu(5'd12, 32'h0000_AAAA);
        tick();
        drive_mdu(5'd10, 32'h0000_BBBB);
        #1;
        chk("refill_mdu_ready", 32'(mdu_ready), 32'd1);
        tick();
        idle_inputs();
        chk("refill_addr12", 32'(rf_waddr), 32'd12);
        chk("refill_data12", rf_wdata, 32'h0000_AAAA);
        for (int k = 0; k < 4; k++) begin
            drive_pipe(1'b1, 5'd13, 32'(k));
            #1;
            chk("refill_pipe_ready", 32'(pipe_ready), 32'd1);
            tick();
            chk("refill_pipe_addr", 32'(rf_waddr), 32'd13);
        end
        #1;
        chk("refill_force_ready", 32'(pipe_ready), 32'd0);
        tick();
        chk("refill_addr10", 32'(rf_waddr), 32'd10);
        chk("refill_data10", rf_wdata, 32'h0000_BBBB);
        idle_inputs();
        tick();
        chk("refill_quiet", 32'(rf_en), 32'd0);

        // MDU result for x0 is dropped: buffer stays empty
        drive_mdu(5'd0, 32'h0000_0F0F);
        tick();
        idle_inputs();
        drive_pipe(1'b1, 5'd13, 32'h0000_0013);
        #1;
        chk("x0_mdu_ready", 32'(mdu_ready), 32'd1);
        tick();
        idle_inputs();
        chk("x0_pipe_addr", 32'(rf_waddr), 32'd13);
        tick();
        chk("x0_no_write", 32'(rf_en), 32'd0);

        // Flush drops buffered x3, clears busy, ignores issue in flush cycle
        mdu_issue_valid = 1'b1;
        mdu_issue_reg   = 5'd3;
        tick();
        idle_inputs();
        chk("busy3_set", busy, 32'h0000_0008);
        drive_mdu(5'd3, 32'h0000_CCCC);
        tick();
        idle_inputs();
        flush           = 1'b1;
        mdu_issue_valid = 1'b1;
        mdu_issue_reg   = 5'd4;
        tick();
        idle_inputs();
        chk("flush_no_write", 32'(rf_en), 32'd0);
        chk("flush_busy", busy, 32'd0);
        tick();
        chk("flush_after_no_write", 32'(rf_en), 32'd0);
        chk("flush_after_busy", busy, 32'd0);
        drive_pipe(1'b1, 5'd0, 32'h0000_5555);
        tick();
        chk("pipe_x0_no_write", 32'(rf_en), 32'd0);
        drive_pipe(1'b0, 5'd6, 32'h0000_6666);
        #1;
        chk("pipe_we0_ready", 32'(pipe_ready), 32'd1);
        tick();
        chk("pipe_we0_no_write", 32'(rf_en), 32'd0);
        drive_pipe(1'b1, 5'd6, 32'h0000_7777);
        flush = 1'b1;
        tick();
        idle_inputs();
        chk("flush_pipe_en", 32'(rf_en), 32'd1);
        chk("flush_pipe_addr", 32'(rf_waddr), 32'd6);
        chk("flush_pipe_data", rf_wdata, 32'h0000_7777);

        // Async reset with the buffer full
        drive_mdu(5'd15, 32'h0000_FFFF);
        drive_pipe(1'b1, 5'd2, 32'h0000_2222);
        tick();
        idle_inputs();
        chk("pre_rst_addr", 32'(rf_waddr), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", 32'(rf_en), 32'd0);
        chk("async_rst_addr", 32'(rf_waddr), 32'd0);
        chk("async_rst_data", rf_wdata, 32'd0);
        chk("async_rst_busy", busy, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_write1", 32'(rf_en), 32'd0);
        tick();
        chk("post_rst_no_write2", 32'(rf_en), 32'd0);
        chk("post_rst_addr", 32'(rf_waddr), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
